// File: rtl/ascon_pkg.sv
// Shared ASCON types and sizes used by the result serializer.
package ascon_pkg;

  localparam int CIPHER_BYTES = 184;
  localparam int TAG_BYTES    = 16;
  localparam int CIPHER_W     = 1472;
  localparam int TAG_W        = 128;
  localparam int FRAME_W      = CIPHER_W + TAG_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_CIPHER = 3'd2,
    S_TAG    = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } ser_state_e;

endpackage

// File: rtl/ascon_result_serializer.sv
// Serializes one ASCON result (ciphertext + tag) into a byte stream with
// optional sync header and trailing XOR checksum, using a valid/ready handshake.
module ascon_result_serializer
  import ascon_pkg::*;
#(
  parameter bit         HEADER_EN = 1'b1,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [1471:0] cipher_i,
  input  logic [127:0]  tag_i,
  input  logic          byte_ready_i,
  output logic [7:0]    byte_o,
  output logic          byte_valid_o,
  output logic          busy_o,
  output logic          done_o
);

  ser_state_e         state_q, state_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         cur_byte;
  logic               xfer;

  // Capture register shifts left on every payload transfer, so the byte on
  // the wire is always the top byte; tag bytes follow cipher bytes naturally.
  assign cur_byte = data_q[FRAME_W-1 -: 8];
  assign xfer     = byte_valid_o & byte_ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          data_d  = {cipher_i, tag_i};
          csum_d  = 8'h00;
          idx_d   = 8'h00;
          state_d = HEADER_EN ? S_HEADER : S_CIPHER;
        end
      end
      S_HEADER: begin
        if (xfer) begin
          idx_d   = 8'h00;
          state_d = S_CIPHER;
        end
      end
      S_CIPHER: begin
        if (xfer) begin
          data_d = {data_q[FRAME_W-9:0], 8'h00};
          csum_d = csum_q ^ cur_byte;
          if (idx_q == 8'(CIPHER_BYTES - 1)) begin
            idx_d   = 8'h00;
            state_d = S_TAG;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_TAG: begin
        if (xfer) begin
          data_d = {data_q[FRAME_W-9:0], 8'h00};
          csum_d = csum_q ^ cur_byte;
          if (idx_q == 8'(TAG_BYTES - 1)) begin
            state_d = S_CHECK;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_CHECK: begin
        if (xfer) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      idx_q   <= 8'h00;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    byte_o       = 8'h00;
    byte_valid_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      S_HEADER: begin
        byte_o       = SYNC_BYTE;
        byte_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_CIPHER, S_TAG: begin
        byte_o       = cur_byte;
        byte_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_CHECK: begin
        byte_o       = csum_q;
        byte_valid_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_DONE:  done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_result_serializer.sv
// Directed bench for ascon_result_serializer: header and headerless frames,
// backpressure, start while busy, reset mid-frame and start in S_DONE.
module tb_ascon_result_serializer;
  import ascon_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start0;
  logic [1471:0] cipher;
  logic [127:0]  tag;
  logic          ready, ready0;
  logic [7:0]    b, b0;
  logic          bv, bv0, busy, busy0, done, done0;

  always #5 clk = ~clk;

  ascon_result_serializer #(.HEADER_EN(1'b1), .SYNC_BYTE(8'hA5)) dut (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .cipher_i(cipher), .tag_i(tag),
    .byte_ready_i(ready), .byte_o(b), .byte_valid_o(bv), .busy_o(busy), .done_o(done)
  );

  ascon_result_serializer #(.HEADER_EN(1'b0), .SYNC_BYTE(8'hA5)) dut0 (
    .clock_i(clk), .reset_i(rst_n), .start_i(start0), .cipher_i(cipher), .tag_i(tag),
    .byte_ready_i(ready0), .byte_o(b0), .byte_valid_o(bv0), .busy_o(busy0), .done_o(done0)
  );

  int pass = 0, total = 0;
  logic [7:0] exp_q [202];
  logic [7:0] got_q [202];
  int exp_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h", name, act, req);
    else pass++;
  endtask

  function automatic logic [1471:0] gen_c(input int pat);
    logic [1471:0] c;
    logic [7:0] k8;
    c = '0;
    for (int k = 0; k < CIPHER_BYTES; k++) begin
      k8 = 8'(k);
      c[1471-8*k -: 8] = (pat == 0) ? 8'h00 : (pat == 1) ? k8 : 8'hFF - k8;
    end
    return c;
  endfunction

  function automatic logic [127:0] gen_t(input int pat);
    return (pat == 0) ? 128'h0 : 128'h0102030405060708090a0b0c0d0e0f10;
  endfunction

  // Reference frame built by byte index from the raw inputs.
  task automatic build_exp(input bit hdr, input logic [1471:0] c, input logic [127:0] t);
    logic [7:0] cs;
    int p;
    cs = 8'h00;
    p = 0;
    if (hdr) begin exp_q[p] = 8'hA5; p++; end
    for (int k = 0; k < CIPHER_BYTES; k++) begin
      exp_q[p] = c[1471-8*k -: 8]; cs ^= exp_q[p]; p++;
    end
    for (int k = 0; k < TAG_BYTES; k++) begin
      exp_q[p] = t[127-8*k -: 8]; cs ^= exp_q[p]; p++;
    end
    exp_q[p] = cs; p++;
    exp_len = p;
  endtask

  task automatic launch(input bit h0, input int pat);
    @(negedge clk);
    cipher = gen_c(pat);
    tag    = gen_t(pat);
    build_exp(!h0, cipher, tag);
    if (h0) start0 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start0 = 1'b0;
  endtask

  // Sinks one frame; returns at the negedge where done_o is seen (or on timeout).
  task automatic collect(input bit h0, input int stall_at, input int bstart_at,
                         output int n, output int errs, output bit lat_ok, output bit done_ok,
                         output int stall_err, output logic [7:0] hold_b, output int busy_low);
    int scnt;
    bit prev, bdone, rdy;
    logic v, bsy, dn;
    logic [7:0] bb;
    n = 0; errs = 0; lat_ok = 0; done_ok = 0; stall_err = 0; hold_b = 8'h00; busy_low = 0;
    scnt = 0; prev = 0; bdone = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      v = h0 ? bv0 : bv; bsy = h0 ? busy0 : busy; dn = h0 ? done0 : done; bb = h0 ? b0 : b;
      if (cyc == 0) lat_ok = v && bsy;
      if (dn) begin done_ok = prev && !bsy && !v; break; end
      if (!bsy) busy_low++;
      rdy = 1'b1;
      if (n == stall_at && v) begin
        if (scnt == 0) hold_b = bb;
        else if (bb !== hold_b) stall_err++;
        if (scnt < 5) begin rdy = 1'b0; scnt++; end
      end
      if (n == stall_at && scnt > 0 && !v) stall_err++;
      if (n == bstart_at && !bdone) begin
        cipher = ~cipher; tag = ~tag;
        if (h0) start0 = 1'b1; else start = 1'b1;
        bdone = 1;
      end else begin
        start = 1'b0; start0 = 1'b0;
      end
      if (h0) ready0 = rdy; else ready = rdy;
      if (v && rdy) begin
        if (n < 202) begin
          got_q[n] = bb;
          if (bb !== exp_q[n]) errs++;
        end else errs++;
        n++; prev = 1;
      end else prev = 0;
      @(negedge clk);
    end
    start = 1'b0; start0 = 1'b0;
  endtask

  typedef struct {
    bit h0; int pat; int stall_at; int bstart_at;
    int len; logic [7:0] first; logic [7:0] last; logic [7:0] hold;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int n, errs, stall_err, busy_low, li;
    bit lat_ok, done_ok, dn_seen;
    logic [7:0] hold_b;

    tbl[0] = '{0, 0, -1, -1, 202, 8'hA5, 8'h00, 8'h00};
    tbl[1] = '{0, 1, -1, -1, 202, 8'hA5, 8'h10, 8'h00};
    tbl[2] = '{0, 1,  4, -1, 202, 8'hA5, 8'h10, 8'h03};
    tbl[3] = '{0, 1, -1, 51, 202, 8'hA5, 8'h10, 8'h00};
    tbl[4] = '{1, 1, -1, -1, 201, 8'h00, 8'h10, 8'h00};
    tbl[5] = '{1, 2, -1, -1, 201, 8'hFF, 8'h10, 8'h00};

    rst_n = 1'b0; start = 1'b0; start0 = 1'b0; ready = 1'b1; ready0 = 1'b1;
    cipher = '0; tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_byte",  32'(b),    32'h0);
    chk("rst_valid", 32'(bv),   32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].h0, tbl[i].pat);
      collect(tbl[i].h0, tbl[i].stall_at, tbl[i].bstart_at,
              n, errs, lat_ok, done_ok, stall_err, hold_b, busy_low);
      li = (n > 0) ? n - 1 : 0;
      chk($sformatf("v%0d_len", i),     32'(n),        32'(tbl[i].len));
      chk($sformatf("v%0d_bytes", i),   32'(errs),     32'h0);
      chk($sformatf("v%0d_first", i),   32'(got_q[0]), 32'(tbl[i].first));
      chk($sformatf("v%0d_last", i),    32'(got_q[li]), 32'(tbl[i].last));
      chk($sformatf("v%0d_latency", i), 32'(lat_ok),   32'h1);
      chk($sformatf("v%0d_done", i),    32'(done_ok),  32'h1);
      chk($sformatf("v%0d_busy", i),    32'(busy_low), 32'h0);
      if (tbl[i].stall_at >= 0) begin
        chk($sformatf("v%0d_stall", i), 32'(stall_err), 32'h0);
        chk($sformatf("v%0d_hold", i),  32'(hold_b),    32'(tbl[i].hold));
      end
      @(negedge clk);
    end

    // start while in S_DONE is dropped; a start one cycle later is honoured
    launch(0, 0);
    collect(0, -1, -1, n, errs, lat_ok, done_ok, stall_err, hold_b, busy_low);
    chk("sd_done", 32'(done_ok), 32'h1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sd_ignored_busy",  32'(busy), 32'h0);
    chk("sd_ignored_state", 32'(dut.state_q), 32'(S_IDLE));
    launch(0, 1);
    collect(0, -1, -1, n, errs, lat_ok, done_ok, stall_err, hold_b, busy_low);
    chk("sd_next_len",   32'(n),    32'd202);
    chk("sd_next_bytes", 32'(errs), 32'h0);
    @(negedge clk);

    // reset after 100 bytes; start held during reset must not launch a frame
    launch(0, 1);
    n = 0;
    ready = 1'b1;
    for (int c = 0; c < 400 && n < 100; c++) begin
      if (bv) n++;
      @(negedge clk);
    end
    chk("mr_reached", 32'(n), 32'd100);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    chk("mr_byte",  32'(b),    32'h0);
    chk("mr_valid", 32'(bv),   32'h0);
    chk("mr_busy",  32'(busy), 32'h0);
    chk("mr_state", 32'(dut.state_q), 32'(S_IDLE));
    dn_seen = 0;
    for (int c = 0; c < 5; c++) begin
      dn_seen |= done;
      dn_seen |= busy;
      @(negedge clk);
    end
    chk("mr_no_done", 32'(dn_seen), 32'h0);
    launch(0, 1);
    collect(0, -1, -1, n, errs, lat_ok, done_ok, stall_err, hold_b, busy_low);
    chk("mr_new_len",   32'(n),       32'd202);
    chk("mr_new_bytes", 32'(errs),    32'h0);
    chk("mr_new_done",  32'(done_ok), 32'h1);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/ascon_result_serializer.md
ASCON_RESULT_SERIALIZER -- requirements
Module: ascon_result_serializer

Interface
REQ-001 The block SHALL have parameter HEADER_EN, default 1, meaning a sync byte is emitted at frame start when 1.
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the value of the sync byte.
REQ-003 clock_i  in  1  single system clock; all logic on rising edge.
REQ-004 reset_i  in  1  reset, synchronous and active-low.
REQ-005 start_i  in  1  one-cycle pulse from the ASCON controller; result words are valid in that cycle.
REQ-006 cipher_i  in  1472  ciphertext; byte 0 = cipher_i[1471:1464].
REQ-007 tag_i  in  128  authentication tag; byte 0 = tag_i[127:120].
REQ-008 byte_ready_i  in  1  downstream (UART TX) accepts byte_o this cycle.
REQ-009 byte_o  out  8  current frame byte.
REQ-010 byte_valid_o  out  1  byte_o holds a valid byte.
REQ-011 busy_o  out  1  frame in progress.
REQ-012 done_o  out  1  one-cycle pulse after the last byte is accepted.

Function
REQ-013 Frame order SHALL be: SYNC_BYTE (only if HEADER_EN=1), 184 cipher bytes MSB first, 16 tag bytes MSB first, 1 checksum byte; 202 bytes with header, 201 without.
REQ-014 Checksum SHALL be the bytewise XOR of all 200 cipher and tag bytes; the header is excluded.
REQ-015 On start_i=1 in S_IDLE, cipher_i and tag_i SHALL be captured into a 1600-bit internal register in that cycle; busy_o and byte_valid_o rise the next cycle (latency 1).
REQ-016 start_i SHALL be ignored while busy_o=1; captured data is not modified.
REQ-017 A byte transfer SHALL occur on any rising edge with byte_valid_o=1 and byte_ready_i=1.
REQ-018 Once byte_valid_o rises, it SHALL stay high and byte_o SHALL stay stable until that byte transfers.
REQ-019 After a transfer the next byte SHALL be presented in the following cycle, so a continuously-ready sink sees one byte per clock with no gaps.
REQ-020 State machine SHALL have states S_IDLE, S_HEADER, S_CIPHER, S_TAG, S_CHECK, S_DONE, with these transitions:
 - S_IDLE -> S_HEADER on start_i when HEADER_EN=1, else -> S_CIPHER.
 - S_HEADER -> S_CIPHER on transfer.
 - S_CIPHER -> S_TAG after the transfer of byte index 183.
 - S_TAG -> S_CHECK after the transfer of tag byte 15.
 - S_CHECK -> S_DONE on transfer.
 - S_DONE -> S_IDLE unconditionally; done_o=1 only in S_DONE.
REQ-021 Byte index SHALL be an 8-bit counter, cleared on entry to S_CIPHER and to S_TAG, and incremented only on a transfer; it never wraps within a frame.
REQ-022 The running checksum SHALL be cleared at capture and updated with each cipher or tag byte on its transfer; the value presented in S_CHECK is final.
REQ-023 busy_o SHALL be 1 in S_HEADER through S_CHECK and 0 in S_IDLE and S_DONE.
REQ-024 A start_i arriving in S_DONE SHALL be ignored; a new frame can start from S_IDLE one cycle later.
REQ-025 byte_valid_o SHALL be 0 in S_IDLE and S_DONE, and byte_o SHALL be 8'h00 there.

Reset
REQ-026 On reset_i=0 at a clock edge the block SHALL, regardless of state, go to S_IDLE and drive:
 - byte_o = 8'h00, byte_valid_o = 0, busy_o = 0, done_o = 0;
 - capture register, byte index and checksum cleared.
REQ-027 Reset mid-frame SHALL abort the frame with no done_o pulse; start_i during reset is ignored.

Structure
REQ-028 The shared package ascon_pkg SHALL hold:
 - the state enum for this block;
 - constants CIPHER_BYTES=184, TAG_BYTES=16, CIPHER_W=1472, TAG_W=128.
REQ-029 No sub-module SHALL be used; the byte index counter and checksum are inline registers.

Verification
REQ-030 Zero data: cipher=0, tag=0, sink always ready, HEADER_EN=1 -> 202 consecutive bytes A5, 200x00, 00, then done_o pulse one cycle after the last transfer.
REQ-031 Pattern data: cipher byte k = k[7:0], tag = 128'h0102..10 -> bytes A5, 00..B7, 01..10, checksum 8'h10.
REQ-032 Backpressure: byte_ready_i low for 5 cycles while cipher byte 3 is presented -> byte_o=8'h03 and byte_valid_o=1 held stable throughout; no byte lost or duplicated.
REQ-033 Busy start: second start_i with different data at byte 50 -> frame completes with the first data only; busy_o remains 1.
REQ-034 Reset mid-frame: reset_i=0 for 1 cycle at byte 100 -> next cycle all outputs 0, state S_IDLE, no done_o; a new start_i then gives a full correct frame.
REQ-035 HEADER_EN=0 with pattern data -> 201 bytes, first byte 8'h00 (cipher_i[1471:1464]), last byte 8'h10.
